instr_fetch_gen: RTL

- Testbench fetch requester that drives the instruction-side OBI interface (req/gnt/rvalid/rdata/err) of the instruction memory model.
- Issues sequential word fetches with bounded outstanding transactions and tracks request addresses in order.
- Returns each response with its matching address to the bench scoreboard.
- Provides standalone protocol/latency stimulus for the memory model under GNT_WMAX/RESP_WMAX/ERR_RATE sweeps.

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_gen_if.sv | 20 ++
 rtl/fetch_addr_fifo.sv | 48 ++++
 rtl/instr_fetch_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch requester: FSM state encoding,
// outstanding-counter width and the response record returned to the bench.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_DRAIN
    } fetch_state_e;

    // Largest supported MAX_OUTSTANDING; the counter is sized for it.
    localparam int MAX_OUTSTANDING_LIMIT = 8;
    localparam int OST_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_gen_if.sv
// Instruction-side OBI bus bundle between the fetch requester (master)
// and the instruction memory model (slave).
interface instr_fetch_gen_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err
    );
endinterface

// File: rtl/fetch_addr_fifo.sv
// In-order address FIFO for granted fetches; head is the oldest
// unanswered address. Push and pop may occur together, also when full.
module fetch_addr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULLC = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;

    // Storage, wrap-around pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
            end
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_full  = (r_cnt == FULLC);
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/instr_fetch_gen.sv
// Instruction fetch requester: issues sequential word fetches on OBI with
// bounded outstanding transactions and returns each response tagged with
// its request address.
// Optional macro INSTR_FETCH_GEN_ASSERT_EN compiles OBI protocol assertions.
module instr_fetch_gen
    import instr_fetch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          start_addr,
    input  logic [CNT_W-1:0]     fetch_cnt,
    input  logic                 stop_on_err,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    instr_fetch_gen_if.master    obi,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_addr,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic [15:0]          err_cnt,
    output logic                 proto_err
);
    localparam logic [OST_W-1:0] MAX_O = OST_W'(MAX_OUTSTANDING);

    fetch_state_e     r_state;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_remaining;
    logic [OST_W-1:0] r_outst;
    logic             r_req;
    logic             r_done;
    logic             r_err_seen;
    logic             r_proto_err;
    logic [15:0]      r_err_cnt;
    logic             r_rsp_valid;
    fetch_rsp_t       r_rsp;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [31:0]      w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_rsp_err;
    logic             w_stop;
    logic [OST_W-1:0] w_outst_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_req_ok;
    logic             w_fetch_end;

    // A grant can only be taken while a slot is free; req is never raised otherwise.
    assign w_push      = r_req & obi.instr_gnt & (~w_fifo_full | w_pop);
    assign w_pop       = obi.instr_rvalid & ~w_fifo_empty;
    assign w_rsp_err   = w_pop & obi.instr_err;
    assign w_stop      = abort | (stop_on_err & (r_err_seen | w_rsp_err));
    assign w_outst_nxt = r_outst + OST_W'(w_push) - OST_W'(w_pop);
    assign w_rem_nxt   = r_remaining - CNT_W'(w_push);
    assign w_req_ok    = (w_rem_nxt != '0) && (w_outst_nxt < MAX_O) && !w_stop;
    // Leave FETCH only when no request is left hanging on the bus.
    assign w_fetch_end = ((w_rem_nxt == '0) || w_stop) && (!r_req || obi.instr_gnt);

    fetch_addr_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_addr),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Run sequencing FSM with all bus, status and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FS_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_outst     <= '0;
            r_req       <= 1'b0;
            r_done      <= 1'b0;
            r_err_seen  <= 1'b0;
            r_proto_err <= 1'b0;
            r_err_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_done  <= 1'b0;
            r_outst <= w_outst_nxt;

            if (w_pop) begin
                r_rsp_valid <= 1'b1;
                r_rsp       <= '{addr: w_head, data: obi.instr_rdata, err: obi.instr_err};
            end else begin
                r_rsp_valid <= 1'b0;
            end

            if (w_rsp_err) begin
                r_err_seen <= 1'b1;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end

            if (obi.instr_rvalid && w_fifo_empty) r_proto_err <= 1'b1;

            case (r_state)
                FS_IDLE: begin
                    if (start) begin
                        if (fetch_cnt != '0) begin
                            r_state     <= FS_FETCH;
                            r_addr      <= start_addr & ~32'h3;
                            r_remaining <= fetch_cnt;
                            r_err_cnt   <= '0;
                            r_err_seen  <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                FS_FETCH: begin
                    if (w_push) begin
                        r_addr      <= r_addr + 32'd4;
                        r_remaining <= w_rem_nxt;
                    end
                    if (w_fetch_end) begin
                        r_state <= FS_DRAIN;
                        r_req   <= 1'b0;
                    end else if (!r_req || obi.instr_gnt) begin
                        r_req <= w_req_ok;
                    end
                end
                FS_DRAIN: begin
                    if (r_outst == '0) begin
                        r_state <= FS_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= FS_IDLE;
            endcase
        end
    end

    assign busy           = (r_state != FS_IDLE);
    assign done           = r_done;
    assign obi.instr_req  = r_req;
    assign obi.instr_addr = r_addr;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_addr       = r_rsp.addr;
    assign rsp_data       = r_rsp.data;
    assign rsp_err        = r_rsp.err;
    assign err_cnt        = r_err_cnt;
    assign proto_err      = r_proto_err;

`ifdef INSTR_FETCH_GEN_ASSERT_EN
    // OBI forbids retracting a request before it is granted.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_req && !obi.instr_gnt) |=> r_req)
        else $error("instr_req dropped before gnt");

    // Address must not move while waiting for grant.
    a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_req && !obi.instr_gnt) |=> $stable(r_addr))
        else $error("instr_addr changed while req && !gnt");

    // Outstanding count must respect the configured bound.
    a_outst_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_outst <= MAX_O)
        else $error("outstanding exceeds MAX_OUTSTANDING");

    // A response cannot arrive in the same cycle as its own grant.
    a_rvalid_same_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !(obi.instr_rvalid && r_req && obi.instr_gnt && (r_outst == '0)))
        else $error("rvalid in the same cycle as its own grant");
`endif
endmodule
